// File: rtl/dma_xfer_sequencer_if.sv
// ============================================================================
// dma_xfer_sequencer_if : descriptor, bus-arbitration and DMA address bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface dma_xfer_sequencer_if;
   logic        instr_valid;
   logic        instr_ready;
   logic [25:0] instruction;
   logic        bus_req;
   logic        bus_ack;
   logic        grant;
   logic [7:0]  next_source;
   logic [7:0]  next_destination;
   logic [7:0]  firstempty;
   logic        IOIP1;
   logic        IOIP2;
   logic        D_IOAck1;
   logic        D_IOAck2;
   logic        done;
   logic        err;
   logic        ip_wrap;

   modport master (
      input  instr_valid, instruction, bus_ack, IOIP1, IOIP2, D_IOAck1, D_IOAck2,
      output instr_ready, bus_req, grant, next_source, next_destination,
             firstempty, done, err, ip_wrap
   );

   modport slave (
      output instr_valid, instruction, bus_ack, IOIP1, IOIP2, D_IOAck1, D_IOAck2,
      input  instr_ready, bus_req, grant, next_source, next_destination,
             firstempty, done, err, ip_wrap
   );
endinterface

`default_nettype wire

// File: rtl/dma_xfer_sequencer.sv
// ============================================================================
// dma_xfer_sequencer : accepts DMA descriptors, arbitrates for the system bus
// and feeds one address pair per granted cycle; also holds the bus for I/O
// interrupt service while walking the IP-buffer pointer.
// Revision 1.0
// ============================================================================
`default_nettype none

module dma_xfer_sequencer #(
   parameter logic [7:0] IO_BASE  = 8'd192,
   parameter logic [7:0] IP_BASE  = 8'd128,
   parameter logic [7:0] IP_LIMIT = 8'd191
) (
   input  wire logic             clock,
   input  wire logic             reset,
   dma_xfer_sequencer_if.master  bus_if
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      XFER    = 3'd2,
      SVC     = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t      state_q;
   logic        ready_q, bus_req_q, grant_q, done_q, err_q, wrap_q, desc_q;
   logic [7:0]  src_q, dst_q, fe_q;
   logic [5:0]  remaining_q;

   logic [7:0]  src_d, dst_d, fe_d;
   logic [3:0]  optype;
   logic        legal, io_pend, io_ack;

   // I/O ports never advance; the last memory word rolls over to address 0.
   function automatic logic [7:0] step_addr(input logic [7:0] a);
      if (a >= IO_BASE)
         return a;
      else if (a == IO_BASE - 8'd1)
         return 8'd0;
      else
         return a + 8'd1;
   endfunction

   assign src_d   = step_addr(src_q);
   assign dst_d   = step_addr(dst_q);
   assign fe_d    = (fe_q == IP_LIMIT) ? IP_BASE : fe_q + 8'd1;
   assign optype  = bus_if.instruction[25:22];
   assign legal   = (optype == 4'b0101) || (optype == 4'b0001) || (optype == 4'b0110);
   assign io_pend = bus_if.IOIP1 | bus_if.IOIP2;
   assign io_ack  = bus_if.D_IOAck1 | bus_if.D_IOAck2;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         bus_req_q   <= 1'b0;
         grant_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wrap_q      <= 1'b0;
         desc_q      <= 1'b0;
         src_q       <= 8'd0;
         dst_q       <= 8'd0;
         fe_q        <= IP_BASE;
         remaining_q <= 6'd0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         wrap_q <= 1'b0;
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (bus_if.instr_valid && ready_q) begin
                  ready_q <= 1'b0;
                  if (!legal) begin
                     err_q <= 1'b1;
                  end else begin
                     src_q       <= bus_if.instruction[21:14];
                     dst_q       <= bus_if.instruction[13:6];
                     remaining_q <= bus_if.instruction[5:0];
                     if (bus_if.instruction[5:0] == 6'd0) begin
                        done_q <= 1'b1;
                     end else begin
                        desc_q    <= 1'b1;
                        bus_req_q <= 1'b1;
                        state_q   <= REQ;
                     end
                  end
               end else if (io_pend) begin
                  ready_q   <= 1'b0;
                  bus_req_q <= 1'b1;
                  state_q   <= REQ;
               end
            end
            REQ: begin
               if (bus_if.bus_ack) begin
                  grant_q <= 1'b1;
                  state_q <= desc_q ? XFER : SVC;
               end
            end
            XFER: begin
               src_q       <= src_d;
               dst_q       <= dst_d;
               remaining_q <= remaining_q - 6'd1;
               if (remaining_q == 6'd1) begin
                  grant_q   <= 1'b0;
                  bus_req_q <= 1'b0;
                  done_q    <= 1'b1;
                  desc_q    <= 1'b0;
                  state_q   <= RELEASE;
               end else if (!bus_if.bus_ack) begin
                  grant_q <= 1'b0;
                  state_q <= REQ;
               end
            end
            SVC: begin
               if (io_ack) begin
                  fe_q   <= fe_d;
                  wrap_q <= (fe_q == IP_LIMIT);
               end
               if (!io_pend) begin
                  grant_q   <= 1'b0;
                  bus_req_q <= 1'b0;
                  state_q   <= RELEASE;
               end else if (!bus_if.bus_ack) begin
                  grant_q <= 1'b0;
                  state_q <= REQ;
               end
            end
            RELEASE: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_if.instr_ready      = ready_q;
   assign bus_if.bus_req          = bus_req_q;
   assign bus_if.grant            = grant_q;
   assign bus_if.next_source      = src_q;
   assign bus_if.next_destination = dst_q;
   assign bus_if.firstempty       = fe_q;
   assign bus_if.done             = done_q;
   assign bus_if.err              = err_q;
   assign bus_if.ip_wrap          = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_xfer_sequencer.sv
// ============================================================================
// tb_dma_xfer_sequencer : directed bench with an address-pair scoreboard and a
// firstempty model checked every cycle.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dma_xfer_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dma_xfer_sequencer_if bif();

   dma_xfer_sequencer dut (
      .clock  (clk),
      .reset  (rst),
      .bus_if (bif)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] exp_q[$];
   logic        en       = 1'b0;
   logic        svc_mode = 1'b0;
   logic [7:0]  m_fe     = 8'd128;
   logic        m_wrap   = 1'b0;
   int          grant_cnt = 0, done_cnt = 0, err_cnt = 0, wrap_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] nxt(input logic [7:0] a);
      return (a >= 8'd192) ? a : ((a == 8'd191) ? 8'd0 : a + 8'd1);
   endfunction

   task automatic push_pairs(input logic [7:0] s, input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({s, d});
         s = nxt(s);
         d = nxt(d);
      end
   endtask

   // Per-cycle scoreboard and IP-pointer model
   always @(negedge clk) begin
      if (en) begin
         logic [15:0] p;
         logic        was_empty;
         chk("firstempty", bif.firstempty, m_fe);
         chk("ip_wrap", bif.ip_wrap, m_wrap);
         was_empty = (exp_q.size() == 0);
         if (bif.grant) begin
            grant_cnt++;
            chk("bus_req_with_grant", bif.bus_req, 1);
            if (!was_empty) begin
               p = exp_q.pop_front();
               chk("next_source", bif.next_source, p[15:8]);
               chk("next_destination", bif.next_destination, p[7:0]);
            end else if (!svc_mode) begin
               chk("unexpected_grant", 1, 0);
            end
         end
         done_cnt += int'(bif.done);
         err_cnt  += int'(bif.err);
         wrap_cnt += int'(bif.ip_wrap);
         m_wrap = 1'b0;
         if (rst) begin
            m_fe = 8'd128;
         end else if (bif.grant && was_empty && svc_mode && (bif.D_IOAck1 || bif.D_IOAck2)) begin
            if (m_fe == 8'd191) begin
               m_fe   = 8'd128;
               m_wrap = 1'b1;
            end else begin
               m_fe = m_fe + 8'd1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bif.instr_ready && n < 200) begin tick(); n++; end
      if (!bif.instr_ready) chk("timeout_ready", 0, 1);
   endtask

   task automatic wait_grant();
      int n = 0;
      while (!bif.grant && n < 200) begin tick(); n++; end
      if (!bif.grant) chk("timeout_grant", 0, 1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!bif.done && n < 200) begin tick(); n++; end
      if (!bif.done) chk("timeout_done", 0, 1);
   endtask

   task automatic send(input logic [1:0] op, input logic [1:0] ty,
                       input logic [7:0] s, input logic [7:0] d, input logic [5:0] cnt);
      wait_ready();
      bif.instr_valid = 1'b1;
      bif.instruction = {op, ty, s, d, cnt};
      tick();
      bif.instr_valid = 1'b0;
   endtask

   task automatic ack_pulse();
      wait_grant();
      bif.D_IOAck1 = 1'b1;
      tick();
      bif.D_IOAck1 = 1'b0;
   endtask

   initial begin
      int g0, d0, e0;
      bif.instr_valid = 1'b0;
      bif.instruction = 26'd0;
      bif.bus_ack     = 1'b0;
      bif.IOIP1       = 1'b0;
      bif.IOIP2       = 1'b0;
      bif.D_IOAck1    = 1'b0;
      bif.D_IOAck2    = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_instr_ready", bif.instr_ready, 0);
      chk("rst_bus_req", bif.bus_req, 0);
      chk("rst_grant", bif.grant, 0);
      chk("rst_src", bif.next_source, 0);
      chk("rst_dst", bif.next_destination, 0);
      chk("rst_firstempty", bif.firstempty, 128);
      rst = 1'b0;
      en  = 1'b1;
      tick();
      chk("ready_after_rst", bif.instr_ready, 1);

      // mem->mem, bus_ack two cycles after bus_req
      g0 = grant_cnt; d0 = done_cnt;
      push_pairs(8'd10, 8'd50, 3);
      send(2'b01, 2'b10, 8'd10, 8'd50, 6'd3);
      chk("t1_bus_req", bif.bus_req, 1);
      chk("t1_ready_low", bif.instr_ready, 0);
      tick(); tick();
      chk("t1_grant_before_ack", bif.grant, 0);
      bif.bus_ack = 1'b1;
      tick();
      chk("t1_grant_latency", bif.grant, 1);
      wait_done();
      chk("t1_release_bus_req", bif.bus_req, 0);
      chk("t1_release_grant", bif.grant, 0);
      tick();
      chk("t1_grant_cycles", grant_cnt - g0, 3);
      chk("t1_done_pulses", done_cnt - d0, 1);

      // mem->IO: source wraps at IO_BASE-1, destination held
      g0 = grant_cnt;
      push_pairs(8'd190, 8'd200, 3);
      send(2'b01, 2'b01, 8'd190, 8'd200, 6'd3);
      wait_done();
      tick();
      chk("t2_grant_cycles", grant_cnt - g0, 3);
      chk("t2_src_after", bif.next_source, 1);
      chk("t2_dst_after", bif.next_destination, 200);

      // count==0 and illegal opcode
      d0 = done_cnt; e0 = err_cnt;
      send(2'b00, 2'b01, 8'd200, 8'd5, 6'd0);
      chk("t3_done_now", bif.done, 1);
      chk("t3_no_req", bif.bus_req, 0);
      tick();
      chk("t3_done_gone", bif.done, 0);
      chk("t3_no_req2", bif.bus_req, 0);
      send(2'b11, 2'b00, 8'd1, 8'd2, 6'd4);
      chk("t3_err_now", bif.err, 1);
      chk("t3_err_no_req", bif.bus_req, 0);
      tick();
      chk("t3_err_gone", bif.err, 0);
      tick();
      chk("t3_still_no_req", bif.bus_req, 0);
      chk("t3_err_pulses", err_cnt - e0, 1);
      chk("t3_done_pulses", done_cnt - d0, 1);

      // I/O service: walk pointer to 190, then 191,128,129 with a wrap
      svc_mode  = 1'b1;
      bif.IOIP1 = 1'b1;
      d0 = done_cnt;
      for (int i = 0; i < 62; i++) ack_pulse();
      chk("t4_fe_190", bif.firstempty, 190);
      ack_pulse();
      chk("t4_fe_191", bif.firstempty, 191);
      ack_pulse();
      chk("t4_fe_128", bif.firstempty, 128);
      chk("t4_wrap", bif.ip_wrap, 1);
      ack_pulse();
      chk("t4_fe_129", bif.firstempty, 129);
      chk("t4_wrap_cnt", wrap_cnt, 1);
      bif.IOIP1 = 1'b0;
      tick();
      chk("t4_rel_grant", bif.grant, 0);
      chk("t4_rel_bus_req", bif.bus_req, 0);
      chk("t4_no_done", bif.done, 0);
      tick();
      svc_mode = 1'b0;
      chk("t4_done_cnt", done_cnt - d0, 0);

      // bus_ack drops after two words, resume at src+2/dst+2
      g0 = grant_cnt;
      push_pairs(8'd20, 8'd60, 4);
      send(2'b01, 2'b10, 8'd20, 8'd60, 6'd4);
      wait_grant();
      tick();
      bif.bus_ack = 1'b0;
      tick();
      chk("t5_grant_drop", bif.grant, 0);
      chk("t5_req_held", bif.bus_req, 1);
      tick(); tick();
      bif.bus_ack = 1'b1;
      wait_grant();
      chk("t5_resume_src", bif.next_source, 22);
      chk("t5_resume_dst", bif.next_destination, 62);
      wait_done();
      tick();
      chk("t5_grant_cycles", grant_cnt - g0, 4);

      // reset mid-XFER
      d0 = done_cnt;
      push_pairs(8'd30, 8'd70, 10);
      send(2'b01, 2'b10, 8'd30, 8'd70, 6'd10);
      wait_grant();
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      chk("t6_rst_grant", bif.grant, 0);
      chk("t6_rst_bus_req", bif.bus_req, 0);
      chk("t6_rst_fe", bif.firstempty, 128);
      chk("t6_rst_ready", bif.instr_ready, 0);
      chk("t6_rst_src", bif.next_source, 0);
      tick(); tick();
      chk("t6_no_done", done_cnt - d0, 0);

      // descriptor and IOIP together: descriptor first, then service
      wait_ready();
      svc_mode  = 1'b1;
      bif.IOIP1 = 1'b1;
      push_pairs(8'd5, 8'd100, 2);
      send(2'b01, 2'b10, 8'd5, 8'd100, 6'd2);
      wait_done();
      tick();
      wait_grant();
      chk("t6_queue_drained", exp_q.size(), 0);
      chk("t6_svc_fe", bif.firstempty, 128);
      ack_pulse();
      chk("t6_svc_fe_inc", bif.firstempty, 129);
      bif.IOIP1 = 1'b0;
      tick();
      chk("t6_svc_rel_grant", bif.grant, 0);
      tick();
      chk("t6_done_cnt", done_cnt - d0, 1);
      chk("t6_final_queue", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
